// File: rtl/bus6507_pkg.sv
// Shared widths and encodings for the 6507 bus responder.
package bus6507_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int SLOW_BIT = 12;
  localparam int PH_W = 9;
  localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/bus6507_phase.sv
// phi0 phase counter: ph runs 0..2*HALF-1, clk0 high in the second half.
// Strobes are high during the eclk whose closing edge moves ph onto the named value.
module bus6507_phase
  import bus6507_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic reset,
  output logic clk0,
  output logic st_0,
  output logic st_half,
  output logic st_rd,
  output logic st_end
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HALF - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(HALF);
  localparam logic [PH_W-1:0] PH_RD   = PH_W'(HALF + 2);

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;

  always_comb begin
    ph_nxt = (ph == PH_LAST) ? '0 : ph + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph   <= '0;
      clk0 <= 1'b0;
    end else begin
      ph   <= ph_nxt;
      clk0 <= (ph_nxt >= PH_HALF);
    end
  end

  assign st_0    = (ph == PH_LAST);
  assign st_half = (ph_nxt == PH_HALF);
  assign st_rd   = (ph_nxt == PH_RD);
  assign st_end  = (ph_nxt == PH_LAST);

endmodule

// File: rtl/bus6507_responder.sv
// Drives phi0/res/rdy to a 6507 model and serves its bus from an external synchronous memory.
// BUS6507_WAITSTATE_EN adds a one-clk0 wait on the first read of the slow (addr[12]=1) region.
module bus6507_responder
  import bus6507_pkg::*;
#(
  parameter int HALF       = 4,
  parameter int RES_CYCLES = 8
) (
  input  logic              eclk,
  input  logic              ereset,
  output logic              clk0,
  output logic              res,
  output logic              rdy,
  input  logic [ADDR_W-1:0] ab,
  input  logic              rw,
  input  logic [DATA_W-1:0] db_i,
  output logic [DATA_W-1:0] db_o,
  output logic              db_t,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  logic       st_0;
  logic       st_half;
  logic       st_rd;
  logic       st_end;
  logic       cyc_rd;
  logic [7:0] res_cnt;

  bus6507_phase #(.HALF(HALF)) u_phase (
    .clk     (eclk),
    .reset   (ereset),
    .clk0    (clk0),
    .st_0    (st_0),
    .st_half (st_half),
    .st_rd   (st_rd),
    .st_end  (st_end)
  );

  always_ff @(posedge eclk) begin
    if (ereset) begin
      res       <= 1'b0;
      res_cnt   <= '0;
      cyc_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      db_o      <= '0;
      db_t      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (st_0) begin
        db_t <= 1'b0;
        // res counts whole clk0 cycles, so it can only rise on a cycle boundary
        if (!res) begin
          if (res_cnt == 8'(RES_CYCLES - 1)) begin
            res <= 1'b1;
          end else begin
            res_cnt <= res_cnt + 8'd1;
          end
        end
      end
      if (st_half) begin
        mem_addr <= ab;
        cyc_rd   <= (rw == RW_READ);
      end
      if (st_rd && cyc_rd && res) begin
        db_o <= mem_rdata;
        db_t <= 1'b1;
      end
      if (st_end && !cyc_rd) begin
        mem_wdata <= db_i;
        mem_we    <= res;
      end
    end
  end

`ifdef BUS6507_WAITSTATE_EN
  logic waited;
  logic rdy_q;

  // Any cycle that does not start a wait clears waited, so only back-to-back slow reads are absorbed.
  always_ff @(posedge eclk) begin
    if (ereset) begin
      waited <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (st_0) begin
      if (res && cyc_rd && mem_addr[SLOW_BIT] && !waited) begin
        rdy_q  <= 1'b0;
        waited <= 1'b1;
      end else begin
        rdy_q  <= 1'b1;
        waited <= 1'b0;
      end
    end
  end

  assign rdy = rdy_q;
`else
  assign rdy = 1'b1;
`endif

endmodule

// File: tb/tb_bus6507_responder.sv
// Bench for bus6507_responder: directed and random bus cycles against a cycle-level reference.
module tb_bus6507_responder;
  import bus6507_pkg::*;

  localparam int HALF       = 4;
  localparam int RES_CYCLES = 8;
  localparam int PERIOD     = 2 * HALF;
  localparam int RES_ECLK   = RES_CYCLES * PERIOD;
`ifdef BUS6507_WAITSTATE_EN
  localparam bit WS_EN = 1'b1;
`else
  localparam bit WS_EN = 1'b0;
`endif

  logic              eclk = 1'b0;
  logic              ereset;
  logic              clk0;
  logic              res;
  logic              rdy;
  logic [ADDR_W-1:0] ab;
  logic              rw;
  logic [DATA_W-1:0] db_i;
  logic [DATA_W-1:0] db_o;
  logic              db_t;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  int vectors = 0;
  int miscompares = 0;

  int          t;
  logic [7:0]  last_db;
  bit          stall_now;
  logic [12:0] last_a;
  bit          last_r;
  logic [7:0]  last_d;
  logic [7:0]  ref_mem [int];

  logic [7:0] mem [0:8191];
  bit         written [0:8191];

  bus6507_responder #(.HALF(HALF), .RES_CYCLES(RES_CYCLES)) dut (
    .eclk      (eclk),
    .ereset    (ereset),
    .clk0      (clk0),
    .res       (res),
    .rdy       (rdy),
    .ab        (ab),
    .rw        (rw),
    .db_i      (db_i),
    .db_o      (db_o),
    .db_t      (db_t),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  always #5 eclk = ~eclk;

  function automatic logic [7:0] init_byte(input logic [12:0] a);
    return 8'hA5 ^ 8'(a - 13'h0123);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [12:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_byte(a);
  endfunction

  // External synchronous memory: data appears one eclk after the address.
  always @(posedge eclk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_byte(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h (eclk %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step();
    @(posedge eclk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    ereset = 1'b1;
    step();
    chk("rst_clk0", 32'(clk0), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_db_t", 32'(db_t), 32'd0);
    chk("rst_db_o", 32'(db_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    ereset    = 1'b0;
    t         = 0;
    last_db   = 8'h00;
    stall_now = 1'b0;
  endtask

  // One bus cycle seen from ph 0; every eclk is compared against the reference.
  task automatic run_cycle(input logic [12:0] a, input bit r, input logic [7:0] d, input int nsteps);
    bit         res_cyc;
    bit         rd_live;
    int         p;
    logic [7:0] exp_db;
    res_cyc = (t >= RES_ECLK);
    ab      = a;
    rw      = r;
    db_i    = d;
    last_a  = a;
    last_r  = r;
    last_d  = d;
    for (int k = 1; k <= nsteps; k++) begin
      step();
      p       = t % PERIOD;
      rd_live = (p >= HALF + 2) && r && res_cyc;
      exp_db  = rd_live ? ref_rd(a) : last_db;
      chk("clk0", 32'(clk0), 32'(p >= HALF));
      chk("res", 32'(res), 32'(t >= RES_ECLK));
      chk("mem_we", 32'(mem_we), 32'((p == PERIOD - 1) && !r && res_cyc));
      chk("db_t", 32'(db_t), 32'(rd_live));
      chk("db_o", 32'(db_o), 32'(exp_db));
      if (p >= HALF) chk("mem_addr", 32'(mem_addr), 32'(a));
      if (p == PERIOD - 1 && !r && res_cyc) begin
        chk("mem_wdata", 32'(mem_wdata), 32'(d));
        ref_mem[int'(a)] = d;
      end
      if (p == PERIOD - 1 && r && res_cyc) last_db = exp_db;
      if (p == 0) stall_now = WS_EN && res_cyc && r && a[SLOW_BIT] && !stall_now;
      chk("rdy", 32'(rdy), 32'(!stall_now));
    end
  endtask

  task automatic rand_cycles(input int n);
    logic [12:0] ra;
    bit          rr;
    logic [7:0]  rd;
    for (int i = 0; i < n; i++) begin
      if (stall_now) begin
        ra = last_a;
        rr = last_r;
        rd = last_d;
      end else begin
        case ($urandom_range(0, 2))
          0:       ra = 13'($urandom);
          1:       ra = 13'($urandom_range(0, 7));
          default: ra = 13'h1000 | 13'($urandom_range(0, 7));
        endcase
        rr = bit'($urandom_range(0, 1));
        rd = 8'($urandom);
      end
      run_cycle(ra, rr, rd, PERIOD);
    end
  endtask

  initial begin
    ereset = 1'b1;
    ab     = '0;
    rw     = 1'b1;
    db_i   = '0;
    t      = 0;

    do_reset();
    rand_cycles(RES_CYCLES);

    run_cycle(13'h0123, 1'b1, 8'h00, PERIOD);
    run_cycle(13'h0080, 1'b0, 8'h3C, PERIOD);
    run_cycle(13'h0080, 1'b1, 8'h00, PERIOD);
    run_cycle(13'h1FFC, 1'b1, 8'h00, PERIOD);
    run_cycle(13'h1FFC, 1'b1, 8'h00, PERIOD);
    run_cycle(13'h0FFC, 1'b1, 8'h00, PERIOD);
    run_cycle(13'h1FFC, 1'b0, 8'h5A, PERIOD);

    rand_cycles(200);

    // Abort a write at ph 5: nothing may reach memory.
    run_cycle(13'h0055, 1'b0, ~ref_rd(13'h0055), HALF + 1);
    do_reset();
    rand_cycles(RES_CYCLES);
    run_cycle(13'h0055, 1'b1, 8'h00, PERIOD);
    rand_cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus6507_responder.md
BUS6507_RESPONDER -- requirements
Module: bus6507_responder

Interface
REQ-001 SHALL have parameter HALF, default 4, eclk cycles per clk0 half-period (legal range 3..255).
REQ-002 SHALL have parameter RES_CYCLES, default 8, clk0 cycles for which res is held low after ereset (legal 2..255).
REQ-003 SHALL use one clock and a synchronous active-high reset: eclk  in  1  emulation clock, sole clock domain.
REQ-004 ereset  in  1  reset, synchronous, active-high.
REQ-005 clk0  out  1  phi0 clock driven to the 6507 model.
REQ-006 res  out  1  6507 reset, active-low.
REQ-007 rdy  out  1  6507 ready, 1 = run.
REQ-008 ab  in  13  CPU address bus.
REQ-009 rw  in  1  CPU read/write, 1 = read.
REQ-010 db_i  in  8  CPU data out.
REQ-011 db_o  out  8  data to CPU.
REQ-012 db_t  out  1  data-bus drive enable toward CPU, 1 = responder drives.
REQ-013 mem_addr  out  13  synchronous memory address.
REQ-014 mem_rdata  in  8  memory read data, valid one eclk after mem_addr.
REQ-015 mem_wdata  out  8  memory write data.
REQ-016 mem_we  out  1  memory write strobe, one eclk wide.

Function
REQ-017 Phase counter ph SHALL count 0..2*HALF-1 and wrap to 0; clk0 = 0 for ph < HALF (phase 1), 1 for ph >= HALF (phase 2).
REQ-018 At ph == HALF SHALL register ab into mem_addr and rw into internal flag cyc_rd.
REQ-019 Read (cyc_rd = 1): at ph == HALF+2 SHALL register mem_rdata into db_o and set db_t = 1; db_t SHALL stay 1 through ph == 2*HALF-1 and clear at ph == 0.
REQ-020 Write (cyc_rd = 0): at ph == 2*HALF-1 SHALL pulse mem_we = 1 for one eclk with mem_wdata = db_i; db_t SHALL remain 0.
REQ-021 db_t SHALL never be 1 while rw = 0 is sampled; on a write cycle db_o holds its previous value.
REQ-022 While res = 0, mem_we SHALL stay 0 and db_t SHALL stay 0; clk0 SHALL keep running.
REQ-023 res SHALL rise at ph == 0 after RES_CYCLES complete clk0 cycles counted from the first ph == 0 after ereset release; thereafter res stays 1 until the next ereset.
REQ-024 With the wait-state feature absent, rdy SHALL be constant 1.
REQ-025 Address wrap: ab is 13 bits; mem_addr SHALL equal ab exactly, with no decoding or mirroring.

Reset
REQ-026 On eclk edge with ereset = 1: ph = 0, clk0 = 0, res = 0, rdy = 1, db_t = 0, db_o = 8'h00, mem_addr = 0, mem_wdata = 0, mem_we = 0, res counter = 0, wait flags cleared.
REQ-027 ereset asserted mid-cycle SHALL abort the cycle: no mem_we pulse, db_t deasserts on the same edge.

Configuration
REQ-028 Macro BUS6507_WAITSTATE_EN SHALL, when defined, enable slow-region wait states: a read cycle with mem_addr[12] = 1 and waited = 0 drives rdy = 0 from the following ph == 0 for exactly one clk0 cycle, sets waited = 1; the repeated read (same address) completes normally and clears waited at its ph == 0.
REQ-029 A write, a read with mem_addr[12] = 0, or a read to a different address SHALL clear waited without inserting a wait.
REQ-030 When BUS6507_WAITSTATE_EN is undefined, wait logic SHALL be absent and rdy tied to 1.

Structure
REQ-031 Package bus6507_pkg SHALL hold ADDR_W = 13, DATA_W = 8, SLOW_BIT = 12 and the read/write encoding constant RW_READ = 1.
REQ-032 Sub-module bus6507_phase SHALL generate ph, clk0 and single-eclk strobes for ph == 0, HALF, HALF+2, 2*HALF-1.
REQ-033 Memory is external to the block; no RAM inferred inside.

Verification (HALF = 4, RES_CYCLES = 8)
REQ-034 Reset release -> clk0 period 8 eclk, res = 0 for exactly 64 eclk then 1, mem_we never asserted.
REQ-035 Read ab = 13'h0123, memory returns 8'hA5 -> mem_addr = 13'h0123 at ph 4, db_o = 8'hA5 and db_t = 1 at ph 6..7, db_t = 0 at ph 0.
REQ-036 Write ab = 13'h0080, db_i = 8'h3C -> single mem_we at ph 7 with mem_wdata = 8'h3C, mem_addr = 13'h0080, db_t = 0 throughout.
REQ-037 ereset pulsed at ph 5 of a write -> no mem_we, outputs return to reset values, res low for 64 eclk again.
REQ-038 With BUS6507_WAITSTATE_EN: read 13'h1FFC twice in a row -> rdy = 0 for exactly one clk0 cycle after the first, none after the second; read 13'h0FFC -> rdy stays 1.
